// File: rtl/ofifo_drain_ctrl_pkg.sv
// rtl/ofifo_drain_ctrl_pkg.sv - shared types and sizing for the OFIFO drain path
package ofifo_drain_ctrl_pkg;

   // Default corelet geometry; the SFU and top-level controller size against the same values.
   localparam int DEF_COL     = 8;
   localparam int DEF_PSUM_BW = 16;
   localparam int DEF_ADDR_W  = 11;

   // Width of one psum row as it leaves the OFIFO and enters PSUM SRAM.
   function automatic int row_width(input int col, input int psum_bw);
      return col * psum_bw;
   endfunction

   localparam int ROW_W = row_width(DEF_COL, DEF_PSUM_BW);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ACC,
      ST_WRITE,
      ST_DONE
   } drain_state_e;

endpackage

// File: rtl/ofifo_drain_ctrl_if.sv
// rtl/ofifo_drain_ctrl_if.sv - OFIFO pop port and PSUM SRAM port seen by the drain controller
interface ofifo_drain_ctrl_if
   import ofifo_drain_ctrl_pkg::*;
#(
   parameter int col     = DEF_COL,
   parameter int psum_bw = DEF_PSUM_BW,
   parameter int ADDR_W  = DEF_ADDR_W
);
   localparam int ROW_BITS = row_width(col, psum_bw);

   logic                ofifo_valid;
   logic [ROW_BITS-1:0] ofifo_out;
   logic                ofifo_rd;
   logic [ADDR_W-1:0]   psum_mem_addr;
   logic                psum_mem_rd;
   logic                psum_mem_wr;
   logic [ROW_BITS-1:0] psum_mem_din;
   logic [ROW_BITS-1:0] psum_mem_dout;

   // The drain controller pops the OFIFO and masters the SRAM port.
   modport master (
      input  ofifo_valid, ofifo_out, psum_mem_dout,
      output ofifo_rd, psum_mem_addr, psum_mem_rd, psum_mem_wr, psum_mem_din
   );

   // The OFIFO and the SRAM together form the far side.
   modport slave (
      output ofifo_valid, ofifo_out, psum_mem_dout,
      input  ofifo_rd, psum_mem_addr, psum_mem_rd, psum_mem_wr, psum_mem_din
   );

endinterface

// File: rtl/ofifo_drain_ctrl_psum_lane_add.sv
// rtl/ofifo_drain_ctrl_psum_lane_add.sv - one signed psum lane add, wrapping or saturating
module psum_lane_add #(
   parameter int psum_bw  = 16,
   parameter bit SATURATE = 1'b0
) (
   input  logic [psum_bw-1:0] a_i,
   input  logic [psum_bw-1:0] b_i,
   output logic [psum_bw-1:0] sum_o
);
   localparam logic [psum_bw-1:0] LANE_MAX = {1'b0, {(psum_bw-1){1'b1}}};
   localparam logic [psum_bw-1:0] LANE_MIN = {1'b1, {(psum_bw-1){1'b0}}};

   logic [psum_bw:0] full_sum;
   logic             overflow;

   // Sign-extended add; the top two bits of the result disagree exactly when the lane overflowed.
   always_comb begin
      full_sum = {a_i[psum_bw-1], a_i} + {b_i[psum_bw-1], b_i};
      overflow = full_sum[psum_bw] ^ full_sum[psum_bw-1];
      sum_o    = full_sum[psum_bw-1:0];
      if (SATURATE && overflow) begin
         sum_o = full_sum[psum_bw] ? LANE_MIN : LANE_MAX;
      end
   end

endmodule

// File: rtl/ofifo_drain_ctrl.sv
// rtl/ofifo_drain_ctrl.sv - drains OFIFO psum rows into consecutive PSUM SRAM rows, overwrite or accumulate
module ofifo_drain_ctrl
   import ofifo_drain_ctrl_pkg::*;
#(
   parameter int col      = DEF_COL,
   parameter int psum_bw  = DEF_PSUM_BW,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter bit SATURATE = 1'b0
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              acc_mode_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W:0]   num_rows_i,
   output logic              busy_o,
   output logic              done_o,
   ofifo_drain_ctrl_if.master bus
);
   localparam int ROW_BITS = row_width(col, psum_bw);

   drain_state_e        state_q;
   logic                acc_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   addr_d;
   logic [ADDR_W:0]     num_q;
   logic [ADDR_W:0]     cnt_q;
   logic [ADDR_W:0]     cnt_d;
   logic [ROW_BITS-1:0] data_q;
   logic [ROW_BITS-1:0] sum_row;
   logic                busy_q;
   logic                done_q;
   logic                wr_q;
   logic                pop;

   // Lane-wise adders for accumulate mode; lanes never carry into each other.
   for (genvar g = 0; g < col; g++) begin : g_lane
      psum_lane_add #(
         .psum_bw  (psum_bw),
         .SATURATE (SATURATE)
      ) u_lane_add (
         .a_i   (data_q[g*psum_bw +: psum_bw]),
         .b_i   (bus.psum_mem_dout[g*psum_bw +: psum_bw]),
         .sum_o (sum_row[g*psum_bw +: psum_bw])
      );
   end

   assign pop    = (state_q == ST_FETCH) && bus.ofifo_valid;
   assign addr_d = addr_q + 1'b1;
   assign cnt_d  = cnt_q + 1'b1;

   // The pop and the SRAM read must land on the same edge as ofifo_valid, so they stay combinational.
   assign bus.ofifo_rd      = pop;
   assign bus.psum_mem_rd   = pop && acc_q;
   assign bus.psum_mem_wr   = wr_q;
   assign bus.psum_mem_addr = addr_q;
   assign bus.psum_mem_din  = data_q;
   assign busy_o            = busy_q;
   assign done_o            = done_q;

   // Drain sequencer: job latch, row fetch, optional accumulate, write-back, completion pulse.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         acc_q   <= 1'b0;
         addr_q  <= '0;
         num_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         wr_q   <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  acc_q  <= acc_mode_i;
                  addr_q <= base_addr_i;
                  num_q  <= num_rows_i;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  if (num_rows_i == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               if (pop) begin
                  data_q <= bus.ofifo_out;
                  if (acc_q) begin
                     state_q <= ST_ACC;
                  end else begin
                     state_q <= ST_WRITE;
                     wr_q    <= 1'b1;
                  end
               end
            end
            ST_ACC: begin
               data_q  <= sum_row;
               state_q <= ST_WRITE;
               wr_q    <= 1'b1;
            end
            ST_WRITE: begin
               addr_q <= addr_d;
               cnt_q  <= cnt_d;
               if (cnt_d == num_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= ST_FETCH;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               addr_q  <= '0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               addr_q  <= '0;
            end
         endcase
      end
   end

endmodule
